forward_unit_param: RTL and testbench
=====================================

// Module: forward_unit_param
// PURPOSE
//   Parametrised successor of the ALU operand forwarding unit. Compares NUM_SRC
//   current-instruction read addresses against DEPTH older in-flight producers.
//   Emits one registered ALU-port mux select per source; the youngest matching
//   producer wins. Adds a load-use stall FSM, a pipeline-hold input and a flush input.
// PARAMETERS
//   AW         2  register address width
//   NUM_SRC    2  operand read ports (0=A, 1=B)
//   DEPTH      2  producer stages compared (stage 1 = previous, stage DEPTH = oldest)
//   EXCL_EN    1  1: reads of register EXCL_REG are never forwarded
//   EXCL_REG   3  excluded register (SP)
//   LOAD_STALL 1  1: enable the load-use stall FSM
//   LOAD_LAT   1  bubble cycles inserted per load-use hazard (>=1)
//   STG_W      derived = max(1, clog2(DEPTH)); SEL_W = STG_W+3
// PORTS
//   clk          in   1                 clock, rising edge
//   rst_n        in   1                 asynchronous active-low reset
//   en           in   1                 1: advance; 0: hold every register
//   flush        in   1                 sync clear: outputs to normal, abort stall
//   rd_addr      in   NUM_SRC*AW        current source register addresses, port p at [p*AW+:AW]
//   rd_valid     in   NUM_SRC           port p actually reads a register
//   wr_en        in   DEPTH             stage k-1 writes the register file
//   wr_addr_a    in   DEPTH*AW          stage write address A
//   wr_addr_b    in   DEPTH*AW          stage write address B
//   wr_addr_sel  in   DEPTH             0: destination is addr A; 1: addr B
//   wr_src       in   DEPTH*3           write-data source (0 MEM, 1 ALU, 2 SP, 3 IN, 4 IMM)
//   fwd_sel      out  NUM_SRC*SEL_W     per port {stage_idx, src[2:0]}; normal = {0,3'b010}
//   fwd_hit      out  NUM_SRC           1: fwd_sel selects a forwarded value
//   stall        out  1                 1: freeze fetch/decode and insert a bubble
// BEHAVIOUR
//   - Reset (rst_n=0, async): fwd_sel = normal on all ports, fwd_hit=0, stall=0, state IDLE, cnt=0.
//   - Destination for stage k: wr_addr_sel[k] ? wr_addr_b[k] : wr_addr_a[k].
//   - Match(p,k): rd_valid[p] & wr_en[k] & dest(k)==rd_addr[p]
//       & !(EXCL_EN & rd_addr[p]==EXCL_REG).
//   - Per port: the lowest k with Match decides. If its src is 0/1/3/4,
//       fwd_sel={k-1,src} and fwd_hit=1. If its src is 2 or 5..7, output normal
//       with fwd_hit=0; older stages are not consulted. No match gives normal.
//   - Latency: all outputs are registered; inputs sampled at edge N appear after edge N.
//   - FSM, states IDLE and STALL:
//       IDLE -> STALL when LOAD_STALL & Match(p,1) & wr_src[1]==0 for any p.
//         On that edge: stall<=1, cnt<=LOAD_LAT-1, all fwd_sel<=normal, fwd_hit<=0.
//       STALL: stall=1, fwd outputs held normal, new hazards ignored.
//         If cnt!=0: cnt decrements. If cnt==0: go to IDLE, stall<=0, and normal
//         match evaluation runs on that same edge with the current inputs.
//   - en=0: state, cnt and outputs hold. flush and the FSM are not evaluated. Reset still acts.
//   - flush=1 & en=1: IDLE, stall<=0, cnt<=0, outputs normal. Flush takes priority
//       over hazard detection on the same edge.
//   - Simultaneous: several ports may hit the same or different stages independently.
//       A stage-1 load hit on one port stalls the whole instruction (all ports normal).
//   - Width rule: stage_idx is zero-extended into STG_W bits. For DEPTH=2 the encoding
//       is 0000/0001/0011/0100 (stage 1), 1000/1001/1011/1100 (stage 2), 0010 normal.
// TESTING
//   1 Reset mid-stall (state STALL, rst_n low) -> stall=0 and fwd_sel normal
//     immediately; no edge needed.
//   2 Stage 1 ALU writes r1 (sel=0, src=1) and stage 2 IMM writes r1; port A reads r1
//     -> next cycle fwd_sel_A=0001, fwd_hit_A=1.
//   3 Only stage 2 IN writes r2; port B reads r2; port A reads r0 with no writer
//     -> fwd_sel_B=1011, fwd_sel_A=0010.
//   4 Stage 1 writes r3 (SP) with src=1; port A reads r3 -> fwd_sel_A=0010, fwd_hit_A=0.
//   5 LOAD_LAT=2, stage 1 MEM writes r1, port A reads r1 -> stall=1 for 2 cycles
//     with outputs normal. Then apply stage 2 MEM r1 -> stall=0, fwd_sel_A=1000.
//   6 en=0 during STALL for 3 cycles -> stall and cnt hold. Then flush=1 with en=1
//     -> stall=0 and all outputs normal.

Source files
------------

// File: rtl/forward_unit_param.sv
// Parametrised ALU operand forwarding unit with a load-use stall FSM.
// Each read port is compared against DEPTH older in-flight producers.
// The youngest matching producer decides that port's registered mux select.
module forward_unit_param #(
    parameter int AW         = 2,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int EXCL_EN    = 1,
    parameter int EXCL_REG   = 3,
    parameter int LOAD_STALL = 1,
    parameter int LOAD_LAT   = 1,
    localparam int STG_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SEL_W     = STG_W + 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic [NUM_SRC*AW-1:0]    rd_addr,
    input  logic [NUM_SRC-1:0]       rd_valid,
    input  logic [DEPTH-1:0]         wr_en,
    input  logic [DEPTH*AW-1:0]      wr_addr_a,
    input  logic [DEPTH*AW-1:0]      wr_addr_b,
    input  logic [DEPTH-1:0]         wr_addr_sel,
    input  logic [DEPTH*3-1:0]       wr_src,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic [NUM_SRC-1:0]       fwd_hit,
    output logic                     stall
);

    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [SEL_W-1:0] NORMAL = SEL_W'(3'b010);

    typedef enum logic {IDLE, STALL} state_t;

    state_t                     state_q, state_n;
    logic [CNT_W-1:0]           cnt_q, cnt_n;
    logic                       stall_q, stall_n;
    logic [NUM_SRC*SEL_W-1:0]   sel_q, sel_n, sel_fwd;
    logic [NUM_SRC-1:0]         hit_q, hit_n, hit_fwd;
    logic [DEPTH*AW-1:0]        dest;
    logic [DEPTH-1:0]           match [NUM_SRC];
    logic                       hazard;

    // Resolve each producer's destination register from its two candidate fields
    always_comb begin
        dest = '0;
        for (int k = 0; k < DEPTH; k++) begin
            dest[k*AW +: AW] = wr_addr_sel[k] ? wr_addr_b[k*AW +: AW] : wr_addr_a[k*AW +: AW];
        end
    end

    // Port/stage match matrix; the excluded register (SP) never forwards
    always_comb begin
        for (int p = 0; p < NUM_SRC; p++) begin
            match[p] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                match[p][k] = rd_valid[p] && wr_en[k]
                              && (dest[k*AW +: AW] == rd_addr[p*AW +: AW])
                              && !((EXCL_EN != 0) && (rd_addr[p*AW +: AW] == AW'(EXCL_REG)));
            end
        end
    end

    // Forwarding choice per port: walk oldest to youngest so the youngest match overrides;
    // a match with a non-forwardable source forces the normal path and hides older stages
    always_comb begin
        sel_fwd = {NUM_SRC{NORMAL}};
        hit_fwd = '0;
        hazard  = 1'b0;
        for (int p = 0; p < NUM_SRC; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (match[p][k]) begin
                    if ((wr_src[k*3 +: 3] == 3'd2) || (wr_src[k*3 +: 3] > 3'd4)) begin
                        sel_fwd[p*SEL_W +: SEL_W] = NORMAL;
                        hit_fwd[p]                = 1'b0;
                    end else begin
                        sel_fwd[p*SEL_W +: SEL_W] = {STG_W'(k), wr_src[k*3 +: 3]};
                        hit_fwd[p]                = 1'b1;
                    end
                end
            end
            hazard = hazard | ((LOAD_STALL != 0) && match[p][0] && (wr_src[2:0] == 3'd0));
        end
    end

    // Next-state logic: flush wins, then the load-use FSM decides between bubbling and forwarding
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        stall_n = stall_q;
        sel_n   = sel_q;
        hit_n   = hit_q;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            stall_n = 1'b0;
            sel_n   = {NUM_SRC{NORMAL}};
            hit_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        state_n = STALL;
                        stall_n = 1'b1;
                        cnt_n   = CNT_W'(LOAD_LAT - 1);
                        sel_n   = {NUM_SRC{NORMAL}};
                        hit_n   = '0;
                    end else begin
                        sel_n = sel_fwd;
                        hit_n = hit_fwd;
                    end
                end
                STALL: begin
                    if (cnt_q != '0) begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        stall_n = 1'b0;
                        sel_n   = sel_fwd;
                        hit_n   = hit_fwd;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers; en low freezes everything except reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            sel_q   <= {NUM_SRC{NORMAL}};
            hit_q   <= '0;
        end else if (en) begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            stall_q <= stall_n;
            sel_q   <= sel_n;
            hit_q   <= hit_n;
        end
    end

    assign fwd_sel = sel_q;
    assign fwd_hit = hit_q;
    assign stall   = stall_q;

endmodule

// File: tb/tb_forward_unit_param.sv
// Directed scoreboard bench for forward_unit_param (AW=2, NUM_SRC=2, DEPTH=2, LOAD_LAT=2).
module tb_forward_unit_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [3:0] rd_addr;
    logic [1:0] rd_valid;
    logic [1:0] wr_en;
    logic [3:0] wr_addr_a;
    logic [3:0] wr_addr_b;
    logic [1:0] wr_addr_sel;
    logic [5:0] wr_src;
    logic [7:0] fwd_sel;
    logic [1:0] fwd_hit;
    logic       stall;

    typedef struct packed {
        logic       stall;
        logic [7:0] sel;
        logic [1:0] hit;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    forward_unit_param #(
        .AW(2), .NUM_SRC(2), .DEPTH(2), .EXCL_EN(1), .EXCL_REG(3),
        .LOAD_STALL(1), .LOAD_LAT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .flush(flush),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .wr_en(wr_en),
        .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b),
        .wr_addr_sel(wr_addr_sel),
        .wr_src(wr_src),
        .fwd_sel(fwd_sel),
        .fwd_hit(fwd_hit),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pushExpect(input logic s, input logic [7:0] sel, input logic [1:0] hit);
        exp_t e;
        e.stall = s;
        e.sel   = sel;
        e.hit   = hit;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL %s scoreboard empty: got size %0d required >0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (stall === e.stall) else begin
                errors++;
                $error("[TB] FAIL %s stall got %b required %b", tag, stall, e.stall);
            end
            checks++;
            assert (fwd_sel === e.sel) else begin
                errors++;
                $error("[TB] FAIL %s fwd_sel got %b required %b", tag, fwd_sel, e.sel);
            end
            checks++;
            assert (fwd_hit === e.hit) else begin
                errors++;
                $error("[TB] FAIL %s fwd_hit got %b required %b", tag, fwd_hit, e.hit);
            end
        end
    endtask

    // Drive one cycle of inputs, record the expected registered result, then check after the edge
    task automatic applyStimulus(input string tag,
                                 input logic [3:0] ra, input logic [1:0] rv,
                                 input logic [1:0] we, input logic [3:0] wa,
                                 input logic [3:0] wb, input logic [1:0] ws,
                                 input logic [5:0] src, input logic en_i, input logic flush_i,
                                 input logic e_stall, input logic [7:0] e_sel,
                                 input logic [1:0] e_hit);
        rd_addr     = ra;
        rd_valid    = rv;
        wr_en       = we;
        wr_addr_a   = wa;
        wr_addr_b   = wb;
        wr_addr_sel = ws;
        wr_src      = src;
        en          = en_i;
        flush       = flush_i;
        pushExpect(e_stall, e_sel, e_hit);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        en = 1'b1; flush = 1'b0;
        rd_addr = '0; rd_valid = '0; wr_en = '0;
        wr_addr_a = '0; wr_addr_b = '0; wr_addr_sel = '0; wr_src = '0;
        #1 rst_n = 1'b0;
        #2;
        pushExpect(1'b0, 8'h22, 2'b00);
        checkOutput("reset_state");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Forwarding patterns (stage 1 = low field, port A = low field)
        applyStimulus("stage1_wins",   4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 0, 8'h21, 2'b01);
        applyStimulus("stage2_imm",    4'b0001, 2'b01, 2'b10, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 0, 8'h2C, 2'b01);
        applyStimulus("en0_hold",      4'b0000, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 6'b000_000, 0, 0, 0, 8'h2C, 2'b01);
        applyStimulus("stage2_in_B",   4'b1000, 2'b11, 2'b10, 4'b1000, 4'b0000, 2'b00, 6'b011_000, 1, 0, 0, 8'hB2, 2'b10);
        applyStimulus("addr_b_sel",    4'b1000, 2'b11, 2'b01, 4'b0000, 4'b0010, 2'b01, 6'b000_001, 1, 0, 0, 8'h12, 2'b10);
        applyStimulus("both_ports",    4'b0101, 2'b11, 2'b01, 4'b0001, 4'b0000, 2'b00, 6'b000_100, 1, 0, 0, 8'h44, 2'b11);
        applyStimulus("sp_src_blocks", 4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b001_010, 1, 0, 0, 8'h22, 2'b00);
        applyStimulus("src7_blocks",   4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b001_111, 1, 0, 0, 8'h22, 2'b00);
        applyStimulus("excl_r3",       4'b0011, 2'b01, 2'b01, 4'b0011, 4'b0000, 2'b00, 6'b000_001, 1, 0, 0, 8'h22, 2'b00);
        applyStimulus("rd_valid_off",  4'b0001, 2'b00, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 0, 8'h22, 2'b00);

        // Load-use stall with two bubbles, forwarding inputs ignored while stalled
        applyStimulus("load_hazard",   4'b0001, 2'b01, 2'b01, 4'b0001, 4'b0000, 2'b00, 6'b000_000, 1, 0, 1, 8'h22, 2'b00);
        applyStimulus("stall_cyc2",    4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 1, 8'h22, 2'b00);
        applyStimulus("stall_exit",    4'b0001, 2'b01, 2'b10, 4'b0100, 4'b0000, 2'b00, 6'b000_000, 1, 0, 0, 8'h28, 2'b01);

        // Hazard on port B while port A could forward: whole instruction bubbles
        applyStimulus("hazard_portB",  4'b0110, 2'b11, 2'b11, 4'b1001, 4'b0000, 2'b00, 6'b001_000, 1, 0, 1, 8'h22, 2'b00);
        applyStimulus("hazB_cyc2",     4'b0000, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 6'b000_000, 1, 0, 1, 8'h22, 2'b00);
        applyStimulus("hazB_exit",     4'b0000, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 6'b000_000, 1, 0, 0, 8'h22, 2'b00);

        // en=0 freezes the stall counter; then flush overrides a pending exit/hazard
        applyStimulus("hold_enter",    4'b0001, 2'b01, 2'b01, 4'b0001, 4'b0000, 2'b00, 6'b000_000, 1, 0, 1, 8'h22, 2'b00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("hold_en0",  4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 0, 0, 1, 8'h22, 2'b00);
        end
        applyStimulus("hold_cnt_kept", 4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 1, 8'h22, 2'b00);
        applyStimulus("flush_exit",    4'b0001, 2'b01, 2'b01, 4'b0001, 4'b0000, 2'b00, 6'b000_000, 1, 1, 0, 8'h22, 2'b00);
        applyStimulus("flush_enter",   4'b0001, 2'b01, 2'b01, 4'b0001, 4'b0000, 2'b00, 6'b000_000, 1, 0, 1, 8'h22, 2'b00);
        applyStimulus("flush_abort",   4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 1, 0, 8'h22, 2'b00);
        applyStimulus("post_flush",    4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 0, 8'h21, 2'b01);

        // Asynchronous reset in the middle of a stall
        applyStimulus("rst_enter",     4'b0001, 2'b01, 2'b01, 4'b0001, 4'b0000, 2'b00, 6'b000_000, 1, 0, 1, 8'h22, 2'b00);
        rst_n = 1'b0;
        #2;
        pushExpect(1'b0, 8'h22, 2'b00);
        checkOutput("reset_mid_stall");
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus("after_reset",   4'b0001, 2'b01, 2'b11, 4'b0101, 4'b0000, 2'b00, 6'b100_001, 1, 0, 0, 8'h21, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
